// File: rtl/product_accumulator_if.sv
// Product-in / result-out stream bundle for the accumulate stage.
// Latency: n/a (wires only).
// Backpressure: valid/ready on both the product and result sides.
interface product_accumulator_if #(
    parameter int N     = 5,
    parameter int ACC_W = 12
);
    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   in_product;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_sum;
    logic             out_ovf;

    // Producer of products / consumer of results (multiplier + downstream side).
    modport master (
        output in_valid, in_product, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf
    );

    // The accumulator itself.
    modport slave (
        input  in_valid, in_product, out_ready,
        output in_ready, out_valid, out_sum, out_ovf
    );
endinterface

// File: rtl/product_accumulator.sv
// Sums each group of TERMS signed products into one signed ACC_W-bit dot-product result.
// Latency: result registered one cycle after the group's last accepted product.
// Backpressure: in_ready = !out_valid | out_ready; a pending undrained result freezes the datapath.
// Optional: PRODUCT_ACCUMULATOR_SATURATE_EN clamps each add to the ACC_W range and reports a sticky
// group overflow on out_ovf; without it the sum wraps at ACC_W bits and out_ovf is tied 0.
module product_accumulator #(
    parameter int N     = 5,
    parameter int TERMS = 4,
    parameter int CNT_W = 2,
    parameter int ACC_W = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    output logic                   busy,
    product_accumulator_if.slave   bus
);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TERMS - 1);

    logic signed [ACC_W-1:0] acc;
    logic        [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] base;
    logic signed [ACC_W-1:0] sum;
    logic                    grp_ovf;
    logic                    accept;
    logic                    drain;
    logic                    last;
    logic        [ACC_W-1:0] out_sum_q;
    logic                    out_valid_q;

    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign drain         = out_valid_q && bus.out_ready;
    // A cleared cycle consumes the product but never completes a group.
    assign last          = accept && !clear && (cnt == LAST_CNT);
    assign busy          = (cnt != '0);
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;

    // Sign-extend the incoming product and start each group from zero.
    always_comb begin
        term = ACC_W'($signed(bus.in_product));
        base = (cnt == '0) ? '0 : acc;
    end

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    localparam logic signed [ACC_W-1:0] MAX_V = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W:0] wide;
    logic                  step_ovf;
    logic                  ovf_acc;
    logic                  out_ovf_q;

    assign bus.out_ovf = out_ovf_q;

    // One guard bit catches the overflow; clamp to the nearer bound and fold into the sticky flag.
    always_comb begin
        wide     = (ACC_W+1)'(base) + (ACC_W+1)'(term);
        step_ovf = (wide[ACC_W] != wide[ACC_W-1]);
        sum      = wide[ACC_W-1:0];
        if (step_ovf) begin
            sum = wide[ACC_W] ? MIN_V : MAX_V;
        end
        grp_ovf  = ((cnt != '0) && ovf_acc) || step_ovf;
    end

    // Sticky overflow for the group in progress and the flag travelling with each result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_acc   <= 1'b0;
            out_ovf_q <= 1'b0;
        end else begin
            if (clear || last) begin
                ovf_acc <= 1'b0;
            end else if (accept) begin
                ovf_acc <= grp_ovf;
            end
            if (last) begin
                out_ovf_q <= grp_ovf;
            end
        end
    end
`else
    // Plain two's-complement wrap; no overflow tracking exists in this build.
    always_comb begin
        sum     = base + term;
        grp_ovf = 1'b0;
    end

    assign bus.out_ovf = grp_ovf;
`endif

    // Group accumulator and term counter; clear aborts the group and discards any same-cycle product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            cnt <= '0;
        end else if (clear || last) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            acc <= sum;
            cnt <= cnt + 1'b1;
        end
    end

    // Result register: loads on the last term, otherwise holds; valid drops only on a drain with no refill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sum_q   <= '0;
            out_valid_q <= 1'b0;
        end else if (last) begin
            out_sum_q   <= sum;
            out_valid_q <= 1'b1;
        end else if (drain) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed check of product_accumulator against a group-level reference model.
// Latency: model expects each result one cycle after its last accepted product.
// Backpressure: in_ready and frozen state are checked every cycle against the model.
module tb_product_accumulator;
    localparam int N     = 5;
    localparam int TERMS = 4;
    localparam int CNT_W = 2;
    localparam int ACC_W = 10;
    localparam int P_W   = 2 * N;
    localparam int MAX_V = (1 << (ACC_W - 1)) - 1;
    localparam int MIN_V = -(1 << (ACC_W - 1));

    logic clk;
    logic rst_n;
    logic clear;
    logic busy;

    product_accumulator_if #(.N(N), .ACC_W(ACC_W)) bus ();

    product_accumulator #(
        .N(N), .TERMS(TERMS), .CNT_W(CNT_W), .ACC_W(ACC_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .busy  (busy),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;

    // Reference state: products of the open group, plus the visible result register.
    int               grp[$];
    bit               m_pend;
    logic [ACC_W-1:0] m_sum;
    bit               m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Sum of a whole group by the arithmetic rules: clamp after every add, or wrap once at the end.
    task automatic fold(output logic [ACC_W-1:0] s, output bit o);
        int t;
        t = 0;
        o = 1'b0;
        foreach (grp[i]) begin
            t = t + grp[i];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
            if (t > MAX_V) begin
                t = MAX_V;
                o = 1'b1;
            end else if (t < MIN_V) begin
                t = MIN_V;
                o = 1'b1;
            end
`endif
        end
        s = t[ACC_W-1:0];
    endtask

    task automatic model_reset();
        grp.delete();
        m_pend = 1'b0;
        m_sum  = '0;
        m_ovf  = 1'b0;
    endtask

    // One clock: drive at the falling edge, check in_ready, advance the model, check outputs after the rise.
    task automatic step(input bit v, input int p, input bit clr, input bit ordy);
        bit       rdy;
        bit       acc;
        bit       drn;
        bit       done;
        logic [31:0] pv;
        @(negedge clk);
        pv             = p;
        bus.in_valid   = v;
        bus.in_product = pv[P_W-1:0];
        clear          = clr;
        bus.out_ready  = ordy;
        #1;
        rdy  = !m_pend || ordy;
        check("in_ready", bus.in_ready, rdy);
        acc  = v && rdy;
        drn  = m_pend && ordy;
        done = 1'b0;
        if (clr) begin
            grp.delete();
        end else if (acc) begin
            grp.push_back(p);
            if (grp.size() == TERMS) begin
                fold(m_sum, m_ovf);
                grp.delete();
                done = 1'b1;
            end
        end
        if (done) m_pend = 1'b1;
        else if (drn) m_pend = 1'b0;
        @(posedge clk);
        #1;
        check("out_valid", bus.out_valid, m_pend);
        check("out_sum",   bus.out_sum,   m_sum);
        check("out_ovf",   bus.out_ovf,   m_ovf);
        check("busy",      busy,          grp.size() != 0);
    endtask

    task automatic idle();
        step(1'b0, 0, 1'b0, 1'b1);
    endtask

    // Reset asserted between edges; outputs must clear without waiting for a clock.
    task automatic async_reset(input string tag);
        @(negedge clk);
        bus.in_valid = 1'b0;
        clear        = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check({tag, "_valid"}, bus.out_valid, 1'b0);
        check({tag, "_sum"},   bus.out_sum,   32'd0);
        check({tag, "_busy"},  busy,          1'b0);
        check({tag, "_ovf"},   bus.out_ovf,   1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        n_vec          = 0;
        n_err          = 0;
        rst_n          = 1'b0;
        clear          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_product = '0;
        bus.out_ready  = 1'b1;
        model_reset();
        #12;
        check("rst_in_ready", bus.in_ready,  1'b1);
        check("rst_valid",    bus.out_valid, 1'b0);
        check("rst_sum",      bus.out_sum,   32'd0);
        check("rst_ovf",      bus.out_ovf,   1'b0);
        check("rst_busy",     busy,          1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic group.
        step(1, 3, 0, 1); step(1, -7, 0, 1); step(1, 12, 0, 1); step(1, 1, 0, 1);
        check("basic_sum", bus.out_sum, 32'd9);
        idle();

        // Back-to-back groups with no bubble; the first overflows a 10-bit accumulator.
        for (int i = 0; i < TERMS; i++) step(1, 256, 0, 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
        check("sat_pos_sum", bus.out_sum, 32'd511);
        check("sat_pos_ovf", bus.out_ovf, 1'b1);
`else
        check("wrap_pos_sum", bus.out_sum, 32'd0);
        check("wrap_pos_ovf", bus.out_ovf, 1'b0);
`endif
        for (int i = 0; i < TERMS; i++) step(1, -16, 0, 1);
        for (int i = 0; i < TERMS; i++) step(1, -256, 0, 1);
        idle();

        // Backpressure: pending result with out_ready low, then drain and accept together.
        for (int i = 0; i < TERMS; i++) step(1, 5, 0, 1);
        for (int i = 0; i < 5; i++) step(1, 77, 0, 0);
        step(1, 9, 0, 1);
        idle();

        // Clear mid-group discards the partial sum and the same-cycle product.
        step(1, 100, 0, 1); step(1, 50, 0, 1); step(1, 7, 1, 1);
        for (int i = 0; i < TERMS; i++) step(1, 1, 0, 1);
        check("clear_sum", bus.out_sum, 32'd4);
        idle();

        // Asynchronous reset mid-group, then while a result is stalled.
        step(1, 2, 0, 1); step(1, 2, 0, 1);
        async_reset("arst_grp");
        for (int i = 0; i < TERMS; i++) step(1, 3, 0, 1);
        step(1, 1, 0, 0); step(1, 1, 0, 0);
        async_reset("arst_pend");
        for (int i = 0; i < TERMS; i++) step(1, 2, 0, 1);
        check("arst_after_sum", bus.out_sum, 32'd8);
        idle();

        // Random traffic: random products, valid, ready and occasional clears.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 1023)) - 512,
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
